// File: rtl/priority_scanner_pkg.sv
// ============================================================================
// Module   : priority_scanner_pkg
// Purpose  : Shared state encoding, scan-direction constants and counter
//            sizing helper for the priority bit scanner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package priority_scanner_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

    // The counter must hold MAX_GRANTS itself, the value reached after the final beat.
    function automatic int cnt_width(input int max_grants);
        return $clog2(max_grants + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/priority_pick.sv
// ============================================================================
// Module   : priority_pick
// Purpose  : Combinational pick of the lowest or highest set bit of a word,
//            returned as one-hot, binary index and an all-zero flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_pick
    import priority_scanner_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_residual,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_zero
);

    logic [IDX_W-1:0] w_idx;

    assign o_zero = ~|i_residual;
    assign o_idx  = w_idx;

    // The last match written wins, so the loop order sets the priority.
    always_comb begin
        w_idx = '0;
        if (i_dir == DIR_MSB) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i_residual[i]) w_idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (i_residual[i]) w_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_onehot[i] = ~o_zero && (w_idx == IDX_W'(i));
        end
    end

endmodule

`default_nettype wire

// File: rtl/priority_bit_scanner.sv
// ============================================================================
// Module   : priority_bit_scanner
// Purpose  : Sequential multi-grant priority encoder; emits up to MAX_GRANTS
//            set bits of a request word, one per beat, as one-hot grants.
// Config   : PRIORITY_SCANNER_DIR_EN enables per-word scan direction (dir_i).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_bit_scanner
    import priority_scanner_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MAX_GRANTS = 4,
    parameter int IDX_W      = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             dir_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic [WIDTH-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_val_o,
    output logic             grant_last_o,
    output logic             grant_empty_o,
    input  logic             grant_ready_i
);

    localparam int               CNT_W = cnt_width(MAX_GRANTS);
    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    state_e           r_state,    w_state_nxt;
    logic [WIDTH-1:0] r_residual, w_residual_nxt;
    logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;

    logic             w_scan_dir;
    logic [WIDTH-1:0] w_onehot;
    logic [IDX_W-1:0] w_idx;
    logic             w_zero;
    logic             w_in_scan;
    logic             w_accept;
    logic             w_last;

    assign w_in_scan = (r_state == SCAN);
    assign w_accept  = (r_state == IDLE) && data_val_i;

`ifdef PRIORITY_SCANNER_DIR_EN
    logic r_dir;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_dir <= DIR_LSB;
        end else if (w_accept) begin
            r_dir <= dir_i;
        end
    end

    assign w_scan_dir = r_dir;
`else
    logic w_unused_dir;

    assign w_unused_dir = dir_i;
    assign w_scan_dir   = DIR_LSB;
`endif

    priority_pick #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_residual (r_residual),
        .i_dir      (w_scan_dir),
        .o_onehot   (w_onehot),
        .o_idx      (w_idx),
        .o_zero     (w_zero)
    );

    // x & (x-1) clears the lowest set bit; zero means at most one bit remains.
    assign w_last = ((r_residual & (r_residual - c_one)) == '0) ||
                    (r_cnt == CNT_W'(MAX_GRANTS - 1));

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state    <= IDLE;
            r_residual <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_residual <= w_residual_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_residual_nxt = r_residual;
        w_cnt_nxt      = r_cnt;
        case (r_state)
            IDLE: begin
                if (data_val_i) begin
                    w_residual_nxt = data_i;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = SCAN;
                end
            end
            SCAN: begin
                if (grant_ready_i) begin
                    w_residual_nxt = r_residual & ~w_onehot;
                    w_cnt_nxt      = r_cnt + CNT_W'(1);
                    if (w_last) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign data_ready_o  = ~w_in_scan;
    assign grant_val_o   = w_in_scan;
    assign grant_o       = w_in_scan ? w_onehot : '0;
    assign grant_idx_o   = w_in_scan ? w_idx : '0;
    assign grant_last_o  = w_in_scan && w_last;
    assign grant_empty_o = w_in_scan && w_zero;

endmodule

`default_nettype wire

// File: tb/tb_priority_bit_scanner.sv
// ============================================================================
// Module   : tb_priority_bit_scanner
// Purpose  : Scoreboard bench for priority_bit_scanner (WIDTH=8, MAX_GRANTS=3);
//            honours PRIORITY_SCANNER_DIR_EN in its reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_priority_bit_scanner;

    localparam int W  = 8;
    localparam int MG = 3;
    localparam int IW = 3;

    typedef struct packed {
        logic [W-1:0]  g;
        logic [IW-1:0] idx;
        logic          last;
        logic          empty;
    } beat_t;

    logic          clk;
    logic          arstn_i;
    logic [W-1:0]  data_i;
    logic          dir_i;
    logic          data_val_i;
    logic          data_ready_o;
    logic [W-1:0]  grant_o;
    logic [IW-1:0] grant_idx_o;
    logic          grant_val_o;
    logic          grant_last_o;
    logic          grant_empty_o;
    logic          grant_ready_i;

    beat_t exp_q[$];
    int    errors      = 0;
    int    checks      = 0;
    int    cyc         = 0;
    int    stall_until = 0;
    int    beats_seen  = 0;
    bit    rand_rdy    = 0;

    priority_bit_scanner #(
        .WIDTH      (W),
        .MAX_GRANTS (MG)
    ) dut (
        .clk_i         (clk),
        .arstn_i       (arstn_i),
        .data_i        (data_i),
        .dir_i         (dir_i),
        .data_val_i    (data_val_i),
        .data_ready_o  (data_ready_o),
        .grant_o       (grant_o),
        .grant_idx_o   (grant_idx_o),
        .grant_val_o   (grant_val_o),
        .grant_last_o  (grant_last_o),
        .grant_empty_o (grant_empty_o),
        .grant_ready_i (grant_ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: forced low until stall_until, otherwise 1 or random.
    initial begin
        grant_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc < stall_until)  grant_ready_i = 1'b0;
            else if (rand_rdy)      grant_ready_i = ($urandom_range(0, 3) != 0);
            else                    grant_ready_i = 1'b1;
        end
    end

    // Reference: list set bits in scan order, keep the first MG, or one empty beat.
    task automatic push_expected(input logic [W-1:0] word, input logic dir);
        int    order[$];
        int    n;
        bit    d;
        beat_t b;
`ifdef PRIORITY_SCANNER_DIR_EN
        d = dir;
`else
        d = 1'b0;
`endif
        for (int k = 0; k < W; k++) begin
            int bitpos;
            bitpos = d ? (W - 1 - k) : k;
            if (word[bitpos]) order.push_back(bitpos);
        end
        if (order.size() == 0) begin
            b.g = '0; b.idx = '0; b.last = 1'b1; b.empty = 1'b1;
            exp_q.push_back(b);
        end else begin
            n = (order.size() < MG) ? order.size() : MG;
            for (int j = 0; j < n; j++) begin
                b.g            = '0;
                b.g[order[j]]  = 1'b1;
                b.idx          = IW'(order[j]);
                b.last         = (j == n - 1);
                b.empty        = 1'b0;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic send(input logic [W-1:0] word, input logic dir, input int stall);
        int n;
        @(negedge clk);
        data_i     = word;
        dir_i      = dir;
        data_val_i = 1'b1;
        n = 0;
        while (!data_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", 32'(data_ready_o), 32'd1);
        if (data_ready_o) begin
            push_expected(word, dir);
            if (stall > 0) stall_until = cyc + 1 + stall;
        end
        @(negedge clk);
        data_val_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !data_ready_o) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: pops on every accepted beat, checks hold under backpressure.
    initial begin
        beat_t b;
        beat_t held;
        bit    hold_v;
        bit    last_v;
        hold_v = 1'b0;
        last_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (!arstn_i) begin
                hold_v = 1'b0;
                last_v = 1'b0;
            end else begin
                chk("ready_is_not_val", 32'(data_ready_o), 32'(!grant_val_o));
                if (last_v) chk("ready_after_last", 32'(data_ready_o), 32'd1);
                last_v = 1'b0;
                if (hold_v && grant_val_o) begin
                    chk("hold_grant", 32'(grant_o), 32'(held.g));
                    chk("hold_idx",   32'(grant_idx_o), 32'(held.idx));
                    chk("hold_last",  32'(grant_last_o), 32'(held.last));
                    chk("hold_empty", 32'(grant_empty_o), 32'(held.empty));
                end
                hold_v = 1'b0;
                if (grant_val_o) begin
                    if (grant_ready_i) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_beat: got grant %0h expected none at %0t",
                                     grant_o, $time);
                        end else begin
                            b = exp_q.pop_front();
                            chk("grant", 32'(grant_o), 32'(b.g));
                            chk("idx",   32'(grant_idx_o), 32'(b.idx));
                            chk("last",  32'(grant_last_o), 32'(b.last));
                            chk("empty", 32'(grant_empty_o), 32'(b.empty));
                        end
                        beats_seen++;
                        last_v = grant_last_o;
                    end else begin
                        hold_v      = 1'b1;
                        held.g      = grant_o;
                        held.idx    = grant_idx_o;
                        held.last   = grant_last_o;
                        held.empty  = grant_empty_o;
                    end
                end
            end
        end
    end

    initial begin
        int b0;
        int n;
        arstn_i    = 1'b0;
        data_i     = '0;
        dir_i      = 1'b0;
        data_val_i = 1'b0;
        #1;
        chk("rst_ready", 32'(data_ready_o), 32'd1);
        chk("rst_val",   32'(grant_val_o), 32'd0);
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_idx",   32'(grant_idx_o), 32'd0);
        chk("rst_last",  32'(grant_last_o), 32'd0);
        chk("rst_empty", 32'(grant_empty_o), 32'd0);
        repeat (3) @(negedge clk);
        arstn_i = 1'b1;

        send(8'hB2, 1'b0, 0); drain();
        send(8'hB2, 1'b1, 0); drain();
        send(8'h00, 1'b0, 0); drain();
        send(8'h05, 1'b0, 3); drain();
        send(8'h81, 1'b1, 0); drain();

        // Asynchronous reset in the middle of a word.
        send(8'hFF, 1'b0, 0);
        b0 = beats_seen;
        n  = 0;
        while (beats_seen == b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("first_ff_beat_seen", 32'(beats_seen > b0), 32'd1);
        @(negedge clk);
        #2;
        arstn_i = 1'b0;
        #1;
        chk("async_rst_val",   32'(grant_val_o), 32'd0);
        chk("async_rst_ready", 32'(data_ready_o), 32'd1);
        chk("async_rst_grant", 32'(grant_o), 32'd0);
        exp_q.delete();
        data_i     = 8'h0F;
        data_val_i = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        data_val_i = 1'b0;
        @(negedge clk);
        arstn_i = 1'b1;
        send(8'h01, 1'b0, 0); drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] w;
            int           mode;
            mode = $urandom_range(0, 3);
            if (mode == 0)      w = '0;
            else if (mode == 1) w = W'(1) << $urandom_range(0, W - 1);
            else                w = W'($urandom);
            send(w, 1'($urandom_range(0, 1)), 0);
        end
        drain();
        rand_rdy = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
